// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the register bank: the move-FSM state
// enumeration and a constant clog2 used to size address ports.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } xfer_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_bank_xfer_fsm.sv
// Register-to-register move controller: IDLE->READ->WRITE->DONE.
// Ports: clk/rst, xfer_req/src/dst request, wr_en/wr_addr (override
// detect), src_addr/src_data read tap, mv_we/mv_addr/mv_data write
// request to the bank, xfer_busy/xfer_done/xfer_conflict status.
module reg_bank_xfer_fsm
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             xfer_req,
    input  logic [AW-1:0]    xfer_src,
    input  logic [AW-1:0]    xfer_dst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    output logic [AW-1:0]    src_addr,
    input  logic [WIDTH-1:0] src_data,
    output logic             mv_we,
    output logic [AW-1:0]    mv_addr,
    output logic [WIDTH-1:0] mv_data,
    output logic             xfer_busy,
    output logic             xfer_done,
    output logic             xfer_conflict
);

    xfer_state_t      state;
    xfer_state_t      state_nxt;
    logic [AW-1:0]    src_q;
    logic [AW-1:0]    dst_q;
    logic [WIDTH-1:0] hold_q;
    logic             conflict_q;
    logic             in_range;
    logic             override;

    // A move touching a non-existent register is silently dropped.
    assign in_range = (int'(src_q) < DEPTH) && (int'(dst_q) < DEPTH);
    assign override = wr_en && (wr_addr == dst_q);

    assign src_addr = src_q;
    assign mv_addr  = dst_q;
    assign mv_data  = hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        xfer_busy     = 1'b1;
        xfer_done     = 1'b0;
        xfer_conflict = 1'b0;
        mv_we         = 1'b0;
        unique case (state)
            IDLE: begin
                xfer_busy = 1'b0;
                if (xfer_req) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                // The external write port wins a same-edge clash.
                mv_we     = in_range && !override;
                state_nxt = DONE;
            end
            DONE: begin
                xfer_done     = 1'b1;
                xfer_conflict = conflict_q;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q      <= '0;
            dst_q      <= '0;
            hold_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            if (state == IDLE && xfer_req) begin
                src_q <= xfer_src;
                dst_q <= xfer_dst;
            end
            if (state == READ) begin
                hold_q <= src_data;
            end
            if (state == WRITE) begin
                conflict_q <= in_range && override;
            end
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Register bank with an external write port, a registered bus read
// port (optionally tri-stated when idle) and a register move engine.
// Ports: clk, rst (async active-low), wr_en/wr_addr/wr_data,
// rd_en/rd_addr, bus_out/bus_oe, xfer_req/xfer_src/xfer_dst,
// xfer_busy/xfer_done/xfer_conflict.
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int DEPTH    = 8,
    parameter  int TRISTATE = 1,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    input  logic             xfer_req,
    input  logic [AW-1:0]    xfer_src,
    input  logic [AW-1:0]    xfer_dst,
    output logic             xfer_busy,
    output logic             xfer_done,
    output logic             xfer_conflict
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] bus_q;
    logic [AW-1:0]    src_addr;
    logic [WIDTH-1:0] src_data;
    logic             mv_we;
    logic [AW-1:0]    mv_addr;
    logic [WIDTH-1:0] mv_data;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok    = int'(wr_addr) < DEPTH;
    assign rd_ok    = int'(rd_addr) < DEPTH;
    assign src_data = (int'(src_addr) < DEPTH) ? regs[src_addr] : '0;

    reg_bank_xfer_fsm #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_xfer (
        .clk          (clk),
        .rst          (rst),
        .xfer_req     (xfer_req),
        .xfer_src     (xfer_src),
        .xfer_dst     (xfer_dst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .src_addr     (src_addr),
        .src_data     (src_data),
        .mv_we        (mv_we),
        .mv_addr      (mv_addr),
        .mv_data      (mv_data),
        .xfer_busy    (xfer_busy),
        .xfer_done    (xfer_done),
        .xfer_conflict(xfer_conflict)
    );

    // mv_we is already suppressed when it targets wr_addr, so the two
    // writes never hit the same register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_en && wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
            if (mv_we) begin
                regs[mv_addr] <= mv_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_q  <= '0;
            bus_oe <= 1'b0;
        end else begin
            bus_oe <= rd_en;
            bus_q  <= (rd_en && rd_ok) ? regs[rd_addr] : '0;
        end
    end

    // Idle data is held at zero; the tri-state variant floats it.
    assign bus_out = (TRISTATE != 0 && !bus_oe) ? {WIDTH{1'bz}} : bus_q;

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: a default instance (DEPTH 8,
// tri-state) and a DEPTH 6 zero-idle instance share all inputs.
module tb_reg_bank;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [2:0]  rd_addr;
    logic        xfer_req;
    logic [2:0]  xfer_src;
    logic [2:0]  xfer_dst;
    wire  [15:0] bus0;
    wire  [15:0] bus1;
    logic        oe0, oe1, busy0, busy1, done0, done1, cf0, cf1;

    int n_cmp;
    int n_bad;
    bit four_state;

    // reference model state
    logic [15:0] m0 [8];
    logic [15:0] m1 [6];
    int          ph;
    int          ms, md;
    logic [15:0] h0, h1;
    bit          c0, c1;
    bit          e_oe, e_busy, e_done, e_cf0, e_cf1;
    logic [15:0] e_bus0, e_bus1;

    reg_bank #(.WIDTH(16), .DEPTH(8), .TRISTATE(1)) u0 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .bus_out(bus0), .bus_oe(oe0),
        .xfer_req(xfer_req), .xfer_src(xfer_src), .xfer_dst(xfer_dst),
        .xfer_busy(busy0), .xfer_done(done0), .xfer_conflict(cf0)
    );

    reg_bank #(.WIDTH(16), .DEPTH(6), .TRISTATE(0)) u1 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .bus_out(bus1), .bus_oe(oe1),
        .xfer_req(xfer_req), .xfer_src(xfer_src), .xfer_dst(xfer_dst),
        .xfer_busy(busy1), .xfer_done(done1), .xfer_conflict(cf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Floating bus: all bits unknown on a 4-state simulator, zero on a
    // 2-state one.
    function automatic bit idle0();
        if (!four_state) return bus0 === 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (!$isunknown(bus0[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_flags();
        e_busy = (ph != 0);
        e_done = (ph == 3);
        e_cf0  = (ph == 3) && c0;
        e_cf1  = (ph == 3) && c1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m0[i] = '0;
        for (int i = 0; i < 6; i++) m1[i] = '0;
        ph = 0; ms = 0; md = 0; h0 = '0; h1 = '0; c0 = 0; c1 = 0;
        e_oe = 0; e_bus0 = '0; e_bus1 = '0;
        model_flags();
    endtask

    // One clock edge of the specified behaviour, from the current inputs.
    task automatic model_edge();
        bit mw0, mw1, hit, ok1;
        mw0 = 0; mw1 = 0;
        e_oe   = rd_en;
        e_bus0 = rd_en ? m0[rd_addr] : 16'h0;
        e_bus1 = (rd_en && rd_addr < 6) ? m1[rd_addr] : 16'h0;
        case (ph)
            0: if (xfer_req) begin
                ms = int'(xfer_src); md = int'(xfer_dst); ph = 1;
            end
            1: begin
                h0 = m0[ms];
                h1 = (ms < 6) ? m1[ms] : 16'h0;
                ph = 2;
            end
            2: begin
                hit = wr_en && (int'(wr_addr) == md);
                ok1 = (ms < 6) && (md < 6);
                c0  = hit;
                mw0 = !hit;
                c1  = ok1 && hit;
                mw1 = ok1 && !hit;
                ph  = 3;
            end
            default: ph = 0;
        endcase
        if (wr_en) m0[wr_addr] = wr_data;
        if (wr_en && wr_addr < 6) m1[wr_addr] = wr_data;
        if (mw0) m0[md] = h0;
        if (mw1) m1[md] = h1;
        model_flags();
    endtask

    task automatic cyc();
        if (!rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wr_en = 0; rd_en = 0; xfer_req = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_in();
        model_reset();
        #3;
        n_cmp++;
        if (oe0 !== 1'b0 || oe1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_oe: got %b/%b want 0/0", oe0, oe1);
        end
        n_cmp++;
        if (!idle0() || bus1 !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h/%h want idle/0000", bus0, bus1);
        end
        n_cmp++;
        if ({busy0, done0, cf0, busy1, done1, cf1} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_status: got %b%b%b want 000",
                     busy0, done0, cf0);
        end
        cyc();
        cyc();
        rst = 1;
    endtask

    task automatic test_write_read();
        wr_en = 1; wr_addr = 3; wr_data = 16'hA5A5;
        cyc();
        idle_in();
        rd_en = 1; rd_addr = 3;
        cyc();
        n_cmp++;
        if (bus0 !== 16'hA5A5 || oe0 !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_rd_r3: got %h oe %b want a5a5 oe 1", bus0, oe0);
        end
        n_cmp++;
        if (bus1 !== 16'hA5A5 || oe1 !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_rd_r3_u1: got %h oe %b want a5a5 oe 1", bus1, oe1);
        end
        idle_in();
    endtask

    task automatic test_idle_bus();
        idle_in();
        cyc();
        n_cmp++;
        if (oe0 !== 1'b0 || !idle0()) begin
            n_bad++;
            $display("FAIL idle_tri: got %h oe %b want zzzz oe 0", bus0, oe0);
        end
        n_cmp++;
        if (oe1 !== 1'b0 || bus1 !== 16'h0000) begin
            n_bad++;
            $display("FAIL idle_zero: got %h oe %b want 0000 oe 0", bus1, oe1);
        end
    endtask

    task automatic test_collision();
        wr_en = 1; wr_addr = 2; wr_data = 16'h0001;
        cyc();
        wr_data = 16'h0F0F;
        rd_en = 1; rd_addr = 2;
        cyc();
        n_cmp++;
        if (bus0 !== 16'h0001) begin
            n_bad++;
            $display("FAIL same_edge_old: got %h want 0001", bus0);
        end
        wr_en = 0;
        cyc();
        n_cmp++;
        if (bus0 !== 16'h0F0F || bus1 !== 16'h0F0F) begin
            n_bad++;
            $display("FAIL same_edge_new: got %h/%h want 0f0f", bus0, bus1);
        end
        idle_in();
    endtask

    task automatic test_out_of_range();
        wr_en = 1; wr_addr = 7; wr_data = 16'h7E7E;
        cyc();
        idle_in();
        rd_en = 1; rd_addr = 7;
        cyc();
        n_cmp++;
        if (bus0 !== 16'h7E7E) begin
            n_bad++;
            $display("FAIL oor_u0_r7: got %h want 7e7e", bus0);
        end
        n_cmp++;
        if (bus1 !== 16'h0000 || oe1 !== 1'b1) begin
            n_bad++;
            $display("FAIL oor_rd_u1: got %h oe %b want 0000 oe 1", bus1, oe1);
        end
        idle_in();
    endtask

    task automatic test_move();
        int nbusy, done_at, ndone, ncf;
        wr_en = 1; wr_addr = 1; wr_data = 16'h1234;
        cyc();
        idle_in();
        xfer_req = 1; xfer_src = 1; xfer_dst = 5;
        nbusy = 0; done_at = 0; ndone = 0; ncf = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            xfer_req = 0;
            if (busy0) nbusy++;
            if (done0) begin ndone++; done_at = i; end
            if (cf0) ncf++;
        end
        n_cmp++;
        if (nbusy != 3) begin
            n_bad++;
            $display("FAIL move_busy_len: got %0d want 3", nbusy);
        end
        n_cmp++;
        if (done_at != 3 || ndone != 1) begin
            n_bad++;
            $display("FAIL move_done: got at %0d x%0d want at 3 x1",
                     done_at, ndone);
        end
        n_cmp++;
        if (ncf != 0) begin
            n_bad++;
            $display("FAIL move_conflict: got %0d want 0", ncf);
        end
        rd_en = 1; rd_addr = 5;
        cyc();
        n_cmp++;
        if (bus0 !== 16'h1234 || bus1 !== 16'h1234) begin
            n_bad++;
            $display("FAIL move_r5: got %h/%h want 1234", bus0, bus1);
        end
        idle_in();
    endtask

    task automatic test_conflict();
        xfer_req = 1; xfer_src = 1; xfer_dst = 5;
        cyc();
        xfer_req = 0;
        cyc();
        wr_en = 1; wr_addr = 5; wr_data = 16'hBEEF;
        rd_en = 1; rd_addr = 5;
        cyc();
        n_cmp++;
        if (done0 !== 1'b1 || cf0 !== 1'b1 || done1 !== 1'b1 || cf1 !== 1'b1) begin
            n_bad++;
            $display("FAIL conflict_flags: got done %b cf %b want 1 1",
                     done0, cf0);
        end
        n_cmp++;
        if (bus0 !== 16'h1234) begin
            n_bad++;
            $display("FAIL conflict_old_rd: got %h want 1234", bus0);
        end
        idle_in();
        rd_en = 1; rd_addr = 5;
        cyc();
        n_cmp++;
        if (bus0 !== 16'hBEEF || bus1 !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL conflict_r5: got %h/%h want beef", bus0, bus1);
        end
        idle_in();
    endtask

    task automatic test_edge_moves();
        // r7 -> r2: real move on u0, discarded on u1 (r7 missing)
        xfer_req = 1; xfer_src = 7; xfer_dst = 2;
        cyc();
        xfer_req = 0;
        cyc();
        cyc();
        n_cmp++;
        if (done0 !== 1'b1 || done1 !== 1'b1 || cf1 !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_move_done: got %b/%b cf %b want 1/1 cf 0",
                     done0, done1, cf1);
        end
        rd_en = 1; rd_addr = 2;
        cyc();
        n_cmp++;
        if (bus0 !== 16'h7E7E || bus1 !== 16'h0F0F) begin
            n_bad++;
            $display("FAIL oor_move_r2: got %h/%h want 7e7e/0f0f", bus0, bus1);
        end
        idle_in();
        // src == dst
        xfer_req = 1; xfer_src = 3; xfer_dst = 3;
        cyc();
        xfer_req = 0;
        cyc();
        cyc();
        n_cmp++;
        if (done0 !== 1'b1 || cf0 !== 1'b0) begin
            n_bad++;
            $display("FAIL self_move_done: got %b cf %b want 1 cf 0", done0, cf0);
        end
        rd_en = 1; rd_addr = 3;
        cyc();
        n_cmp++;
        if (bus0 !== 16'hA5A5) begin
            n_bad++;
            $display("FAIL self_move_r3: got %h want a5a5", bus0);
        end
        idle_in();
        cyc();
    endtask

    task automatic test_reset_mid();
        int ndone;
        wr_en = 1; wr_addr = 4; wr_data = 16'h7777;
        cyc();
        idle_in();
        xfer_req = 1; xfer_src = 4; xfer_dst = 6;
        cyc();
        xfer_req = 0;
        rst = 0;
        model_reset();
        #1;
        n_cmp++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_busy: got %b/%b want 0/0", busy0, done0);
        end
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (done0 || done1) ndone++;
        end
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (done0 || done1) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++;
            $display("FAIL rst_mid_nodone: got %0d want 0", ndone);
        end
        rd_en = 1; rd_addr = 4;
        xfer_req = 1; xfer_src = 4; xfer_dst = 6;
        cyc();
        n_cmp++;
        if (bus0 !== 16'h0000 || busy0 !== 1'b1 || busy1 !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_after: got r4 %h busy %b want 0000 busy 1",
                     bus0, busy0);
        end
        idle_in();
        cyc();
        cyc();
        n_cmp++;
        if (done0 !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_redo: got done %b want 1", done0);
        end
        cyc();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 16'($urandom);
            rd_en    = ($urandom_range(0, 1) == 1);
            rd_addr  = 3'($urandom_range(0, 7));
            xfer_req = ($urandom_range(0, 3) == 0);
            xfer_src = 3'($urandom_range(0, 7));
            xfer_dst = 3'($urandom_range(0, 7));
            cyc();
            n_cmp++;
            if (e_oe ? (bus0 !== e_bus0) : !idle0()) begin
                n_bad++;
                $display("FAIL rnd_bus0 @%0d: got %h want %h (oe %b)",
                         i, bus0, e_bus0, e_oe);
            end
            n_cmp++;
            if (bus1 !== e_bus1) begin
                n_bad++;
                $display("FAIL rnd_bus1 @%0d: got %h want %h", i, bus1, e_bus1);
            end
            n_cmp++;
            if ({oe0, busy0, done0, cf0} !== {e_oe, e_busy, e_done, e_cf0}) begin
                n_bad++;
                $display("FAIL rnd_flags0 @%0d: got %b%b%b%b want %b%b%b%b", i,
                         oe0, busy0, done0, cf0, e_oe, e_busy, e_done, e_cf0);
            end
            n_cmp++;
            if ({oe1, busy1, done1, cf1} !== {e_oe, e_busy, e_done, e_cf1}) begin
                n_bad++;
                $display("FAIL rnd_flags1 @%0d: got %b%b%b%b want %b%b%b%b", i,
                         oe1, busy1, done1, cf1, e_oe, e_busy, e_done, e_cf1);
            end
        end
        idle_in();
    endtask

    initial begin
        logic probe;
        probe = 1'bx;
        four_state = $isunknown(probe);
        n_cmp = 0;
        n_bad = 0;
        wr_addr = 0; wr_data = 0; rd_addr = 0;
        xfer_src = 0; xfer_dst = 0;
        idle_in();
        test_reset();
        test_write_read();
        test_idle_bus();
        test_collision();
        test_out_of_range();
        test_move();
        test_conflict();
        test_edge_moves();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
